video_line_writer: RTL



---
 rtl/video_line_writer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/video_line_writer.sv
// Packs visible capture pixels into a RAM line ring and publishes completed lines; writes appear 1 clock after commit.
// No backpressure on the pixel stream: when every slot is still unconsumed the line is dropped and overflow sticks.
module video_line_writer #(
  parameter int SLOT_BITS    = 2,
  parameter int H_ACTIVE     = 720,
  parameter int V_ACTIVE     = 480,
  parameter int H_ACTIVE_DBL = 640,
  parameter int V_ACTIVE_DBL = 240,
  parameter int TRIGGER_LINE = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             red,
  input  logic [7:0]             green,
  input  logic [7:0]             blue,
  input  logic [11:0]            counterX,
  input  logic [11:0]            counterY,
  input  logic                   line_doubler,
  input  logic                   add_line,
  input  logic                   line_consumed,
  output logic                   wren,
  output logic [SLOT_BITS+9:0]   wraddr,
  output logic [23:0]            wrdata,
  output logic                   line_ready,
  output logic [SLOT_BITS-1:0]   ready_slot,
  output logic [9:0]             ready_line,
  output logic [SLOT_BITS:0]     fill,
  output logic                   overflow,
  output logic                   frame_240p,
  output logic                   starttrigger
);

  localparam logic [SLOT_BITS:0] FILL_MAX = {1'b1, {SLOT_BITS{1'b0}}};
  localparam logic [11:0] HA_N = 12'(H_ACTIVE);
  localparam logic [11:0] VA_N = 12'(V_ACTIVE);
  localparam logic [11:0] HA_D = 12'(H_ACTIVE_DBL);
  localparam logic [11:0] VA_D = 12'(V_ACTIVE_DBL);
  localparam logic [9:0]  TRIG = 10'(TRIGGER_LINE);

  typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, BLANK, DROP} state_t;

  state_t               state_q, state_d;
  logic [11:0]          x_prev_q;
  logic [11:0]          ha_q, ha_d, va_q, va_d;
  logic [SLOT_BITS-1:0] wr_slot_q, wr_slot_d, slot_next;
  logic [9:0]           cur_line_q, cur_line_d;
  logic [SLOT_BITS:0]   fill_q, fill_d;
  logic                 overflow_q, overflow_d, frame_240p_q, frame_240p_d;
  logic                 starttrigger_q, starttrigger_d;
  logic                 wren_q, wren_d, line_ready_q, line_ready_d;
  logic [SLOT_BITS+9:0] wraddr_q, wraddr_d;
  logic [23:0]          wrdata_q, wrdata_d;
  logic [SLOT_BITS-1:0] ready_slot_q, ready_slot_d;
  logic [9:0]           ready_line_q, ready_line_d;

  logic        commit, line_start, frame_start, consume, publish, full;
  logic [11:0] ha_eff, va_eff;

  always_comb begin
    commit      = (counterX != x_prev_q);
    line_start  = (counterX == 12'd0) && (x_prev_q != 12'd0);
    frame_start = line_start && (counterY == 12'd0);
    ha_eff      = frame_start ? (line_doubler ? HA_D : HA_N) : ha_q;
    va_eff      = frame_start ? (line_doubler ? VA_D : VA_N) : va_q;
    consume     = line_consumed && (fill_q != '0);

    state_d        = state_q;
    ha_d           = ha_q;
    va_d           = va_q;
    wr_slot_d      = wr_slot_q;
    cur_line_d     = cur_line_q;
    overflow_d     = overflow_q;
    frame_240p_d   = frame_240p_q;
    starttrigger_d = starttrigger_q;
    wren_d         = 1'b0;
    wraddr_d       = wraddr_q;
    wrdata_d       = wrdata_q;
    line_ready_d   = 1'b0;
    ready_slot_d   = ready_slot_q;
    ready_line_d   = ready_line_q;
    publish        = 1'b0;

    case (state_q)
      ACTIVE: begin
        // A line start while still ACTIVE means the line ended short.
        if (line_start) begin
          publish = 1'b1;
        end else if (commit && (counterX < ha_q)) begin
          wren_d   = 1'b1;
          wraddr_d = {wr_slot_q, counterX[9:0]};
          wrdata_d = {red, green, blue};
          if (counterX == ha_q - 12'd1) begin
            publish = 1'b1;
            state_d = BLANK;
          end
        end
      end
      BLANK: if (counterY >= va_q) state_d = WAIT_FRAME;
      default: ;
    endcase

    slot_next = publish ? wr_slot_q + 1'b1 : wr_slot_q;
    fill_d    = fill_q;
    if (publish) fill_d = fill_d + 1'b1;
    if (consume) fill_d = fill_d - 1'b1;
    full = (fill_d == FILL_MAX);

    if (publish) begin
      line_ready_d = 1'b1;
      ready_slot_d = wr_slot_q;
      ready_line_d = cur_line_q;
      wr_slot_d    = slot_next;
      if (cur_line_q == TRIG) starttrigger_d = 1'b1;
    end

    // The new line's first pixel commits on the line-start clock itself.
    if (line_start && (frame_start || state_q != WAIT_FRAME)) begin
      if (frame_start) begin
        ha_d         = ha_eff;
        va_d         = va_eff;
        frame_240p_d = add_line;
      end
      if (counterY < va_eff) begin
        if (full) begin
          state_d    = DROP;
          overflow_d = 1'b1;
        end else begin
          state_d    = ACTIVE;
          cur_line_d = counterY[9:0];
          if (ha_eff != 12'd0) begin
            wren_d   = 1'b1;
            wraddr_d = {slot_next, counterX[9:0]};
            wrdata_d = {red, green, blue};
          end
        end
      end else begin
        state_d = WAIT_FRAME;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= WAIT_FRAME;
      x_prev_q       <= '0;
      ha_q           <= HA_N;
      va_q           <= VA_N;
      wr_slot_q      <= '0;
      cur_line_q     <= '0;
      fill_q         <= '0;
      overflow_q     <= 1'b0;
      frame_240p_q   <= 1'b0;
      starttrigger_q <= 1'b0;
      wren_q         <= 1'b0;
      wraddr_q       <= '0;
      wrdata_q       <= '0;
      line_ready_q   <= 1'b0;
      ready_slot_q   <= '0;
      ready_line_q   <= '0;
    end else begin
      state_q        <= state_d;
      x_prev_q       <= counterX;
      ha_q           <= ha_d;
      va_q           <= va_d;
      wr_slot_q      <= wr_slot_d;
      cur_line_q     <= cur_line_d;
      fill_q         <= fill_d;
      overflow_q     <= overflow_d;
      frame_240p_q   <= frame_240p_d;
      starttrigger_q <= starttrigger_d;
      wren_q         <= wren_d;
      wraddr_q       <= wraddr_d;
      wrdata_q       <= wrdata_d;
      line_ready_q   <= line_ready_d;
      ready_slot_q   <= ready_slot_d;
      ready_line_q   <= ready_line_d;
    end
  end

  assign wren         = wren_q;
  assign wraddr       = wraddr_q;
  assign wrdata       = wrdata_q;
  assign line_ready   = line_ready_q;
  assign ready_slot   = ready_slot_q;
  assign ready_line   = ready_line_q;
  assign fill         = fill_q;
  assign overflow     = overflow_q;
  assign frame_240p   = frame_240p_q;
  assign starttrigger = starttrigger_q;

endmodule
